ex_mem_stage: RTL
=================

Name: ex_mem_stage

Overview:
- EX/MEM pipeline stage directly downstream of the ALU.
- Captures the ALU result, zero flag, store data, destination register and MEM/WB control bits.
- Resolves beq/bne from the zero flag and presents one buffered entry to the data-memory stage over a valid/ready handshake.
- Holds a 2-entry skid buffer so downstream stalls never drop an ALU result.

Parameters:
DATA_W, 32, width of ALU result, store data and branch target
REG_ADDR_W, 5, width of destination register index

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
in_valid_i  in  1  upstream entry valid
in_ready_o  out  1  stage can accept an entry this cycle
alu_result_i  in  DATA_W  ALU result_o
alu_zero_i  in  1  ALU zero_o
rt_data_i  in  DATA_W  store data (rt register value)
rd_addr_i  in  REG_ADDR_W  destination register index
branch_target_i  in  DATA_W  precomputed PC+4+(imm<<2)
ctrl_i  in  6  {reg_write, mem_read, mem_write, mem_to_reg, branch, branch_ne}
flush_i  in  1  kill all buffered entries
out_valid_o  out  1  head entry valid
out_ready_i  in  1  downstream accepts head entry
alu_result_o  out  DATA_W  head ALU result
rt_data_o  out  DATA_W  head store data
rd_addr_o  out  REG_ADDR_W  head destination index
ctrl_o  out  4  head {reg_write, mem_read, mem_write, mem_to_reg}
redirect_o  out  1  one-cycle pulse: taken branch leaving stage
redirect_pc_o  out  DATA_W  branch target, valid while redirect_o is high

Behaviour:
- Reset (rst_i low, asynchronous):
  - Head and skid valid bits are cleared.
  - All data registers are 0.
  - out_valid_o=0, redirect_o=0, in_ready_o=1.
- Transfers:
  - Accept occurs when in_valid_i & in_ready_o.
  - Drain occurs when out_valid_o & out_ready_i.
- Branch taken: taken = branch & (alu_zero_i XOR branch_ne), computed at accept and stored per entry. Entries with branch=0 are never taken.
- Latency: an entry accepted into an empty stage appears on the outputs the next cycle.
- in_ready_o = !skid_valid. It is purely registered, with no combinational path from out_ready_i.
- Buffer state transitions:
  - EMPTY: accept -> HEAD.
  - HEAD, no drain: accept -> FULL (entry to skid).
  - HEAD, drain without accept -> EMPTY.
  - HEAD, drain with accept -> HEAD (head replaced by the new entry).
  - FULL, drain -> HEAD (skid moves to head). No accept is possible while FULL.
- Order is strictly FIFO. Outputs are stable while out_valid_o & !out_ready_i.
- redirect_o:
  - Asserted in the same cycle as a drain whose head entry is taken, combinational from the head register and out_ready_i.
  - redirect_pc_o = head branch_target, 0 otherwise.
- flush_i:
  - Synchronous. Next cycle both valids are 0.
  - Overrides a same-cycle accept; the accepted entry is discarded.
  - redirect_o is forced to 0 in the flush cycle.
- Non-head data registers hold their values; only valid bits qualify them.

Optional Feature:
EX_MEM_STALL_CNT_EN
- Defined:
  - Adds output stall_cnt_o [31:0], counting cycles with out_valid_o & !out_ready_i.
  - The counter saturates at 32'hFFFFFFFF, resets to 0 and is not cleared by flush_i.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Package ex_mem_pkg:
  - DATA_W and REG_ADDR_W defaults.
  - Ctrl bit-index constants (CTRL_REG_WRITE..CTRL_BRANCH_NE).
  - typedef ex_mem_entry_t {alu_result, rt_data, rd_addr, ctrl[3:0], taken, target}.
- Sub-module ex_mem_skid_buf: generic 2-entry valid/ready skid buffer over ex_mem_entry_t, with flush.
- The top level does branch resolution, entry packing and the optional counter.

Test Plan:
- Reset mid-stream with head and skid full, rst_i low -> out_valid_o=0 and in_ready_o=1 immediately; after release, the first accepted entry appears next cycle.
- Single accept with alu_result_i=32'h0000_0010, rd_addr_i=5'd8, reg_write=1, out_ready_i=1 -> next cycle out_valid_o=1, alu_result_o=32'h10, rd_addr_o=8; one cycle later out_valid_o=0.
- Back-pressure:
  - Stimulus: out_ready_i=0, entries A=32'h1, B=32'h2, C=32'h3 offered on consecutive cycles.
  - Response: A and B are accepted, in_ready_o=0 while C is offered; outputs hold A.
  - Release: out_ready_i=1 -> order A, B, C, no loss or duplication.
- beq taken:
  - Stimulus: branch=1, branch_ne=0, alu_zero_i=1, branch_target_i=32'h0000_0040.
  - Response: on drain, redirect_o=1 for exactly 1 cycle with redirect_pc_o=32'h40.
  - Same entry with alu_zero_i=0 -> redirect_o stays 0.
- bne taken: branch=1, branch_ne=1, alu_zero_i=0 -> redirect_o pulses on drain; with alu_zero_i=1 -> no pulse.
- Flush with stage FULL and a new accept in the same cycle -> next cycle out_valid_o=0, in_ready_o=1, no redirect_o; the next accepted entry is the first output seen.

Source files
------------

// File: rtl/ex_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ex_mem_pkg : shared widths, control bit indices and entry type for the   |
// |              EX/MEM pipeline stage.                                      |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package ex_mem_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  // Bit positions inside ctrl_i = {reg_write, mem_read, mem_write, mem_to_reg, branch, branch_ne}
  localparam int CTRL_REG_WRITE  = 5;
  localparam int CTRL_MEM_READ   = 4;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_MEM_TO_REG = 2;
  localparam int CTRL_BRANCH     = 1;
  localparam int CTRL_BRANCH_NE  = 0;

  typedef struct packed {
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     rt_data;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [3:0]            ctrl;
    logic                  taken;
    logic [DATA_W-1:0]     target;
  } ex_mem_entry_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_HEAD  = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

endpackage
`default_nettype wire

// File: rtl/ex_mem_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ex_mem_if : upstream (ALU side) and downstream (MEM side) signals of the |
// |             EX/MEM stage, with master (environment) / slave (stage) views|
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
interface ex_mem_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_W-1:0]     alu_result_i;
  logic                  alu_zero_i;
  logic [DATA_W-1:0]     rt_data_i;
  logic [REG_ADDR_W-1:0] rd_addr_i;
  logic [DATA_W-1:0]     branch_target_i;
  logic [5:0]            ctrl_i;
  logic                  flush_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_W-1:0]     alu_result_o;
  logic [DATA_W-1:0]     rt_data_o;
  logic [REG_ADDR_W-1:0] rd_addr_o;
  logic [3:0]            ctrl_o;
  logic                  redirect_o;
  logic [DATA_W-1:0]     redirect_pc_o;

  modport slave (
    input  in_valid_i, alu_result_i, alu_zero_i, rt_data_i, rd_addr_i,
           branch_target_i, ctrl_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, alu_result_o, rt_data_o, rd_addr_o,
           ctrl_o, redirect_o, redirect_pc_o
  );

  modport master (
    output in_valid_i, alu_result_i, alu_zero_i, rt_data_i, rd_addr_i,
           branch_target_i, ctrl_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, alu_result_o, rt_data_o, rd_addr_o,
           ctrl_o, redirect_o, redirect_pc_o
  );
endinterface
`default_nettype wire

// File: rtl/ex_mem_skid_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ex_mem_skid_buf : 2-entry valid/ready skid buffer of ex_mem_entry_t with |
// |                   synchronous flush; ready and valid are registered.     |
// | Revision        : 1.0 - initial release                                  |
// +--------------------------------------------------------------------------+
module ex_mem_skid_buf
  import ex_mem_pkg::*;
(
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  input  wire logic          i_flush,
  input  wire logic          i_valid,
  output      logic          o_ready,
  input  wire ex_mem_entry_t i_entry,
  output      logic          o_valid,
  input  wire logic          i_ready,
  output      ex_mem_entry_t o_entry
);

  buf_state_t    r_state;
  ex_mem_entry_t r_head;
  ex_mem_entry_t r_skid;
  logic          r_out_valid;
  logic          r_in_ready;
  logic          w_accept;
  logic          w_drain;

  assign w_accept = i_valid & r_in_ready;
  assign w_drain  = r_out_valid & i_ready;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= BUF_EMPTY;
      r_head      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (i_flush) begin
      // A same-cycle accept is dropped; stale data stays behind cleared valids.
      r_state     <= BUF_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        BUF_EMPTY: begin
          if (w_accept) begin
            r_head      <= i_entry;
            r_state     <= BUF_HEAD;
            r_out_valid <= 1'b1;
          end
        end
        BUF_HEAD: begin
          if (w_drain && w_accept) begin
            r_head <= i_entry;
          end else if (w_drain) begin
            r_state     <= BUF_EMPTY;
            r_out_valid <= 1'b0;
          end else if (w_accept) begin
            r_skid     <= i_entry;
            r_state    <= BUF_FULL;
            r_in_ready <= 1'b0;
          end
        end
        BUF_FULL: begin
          if (w_drain) begin
            r_head     <= r_skid;
            r_state    <= BUF_HEAD;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= BUF_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready = r_in_ready;
  assign o_valid = r_out_valid;
  assign o_entry = r_head;

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ex_mem_stage : EX/MEM pipeline stage - branch resolution, entry packing  |
// |                and 2-entry skid buffering toward the data-memory stage.  |
// |                Optional stall counter: define EX_MEM_STALL_CNT_EN.       |
// | Revision     : 1.0 - initial release                                     |
// +--------------------------------------------------------------------------+
module ex_mem_stage #(
  parameter int DATA_W     = ex_mem_pkg::DATA_W,
  parameter int REG_ADDR_W = ex_mem_pkg::REG_ADDR_W
) (
  input  wire logic  clk_i,
  input  wire logic  rst_i,
  ex_mem_if.slave    bus
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output      logic [31:0] stall_cnt_o
`endif
);
  import ex_mem_pkg::*;

  ex_mem_entry_t         w_in_entry;
  ex_mem_entry_t         w_head;
  logic [REG_ADDR_W-1:0] w_rd_addr;
  logic                  w_taken;
  logic                  w_head_valid;
  logic                  w_in_ready;
  logic                  w_redirect;

  // Taken is resolved once at accept so the head never depends on live ALU flags.
  assign w_taken   = bus.ctrl_i[CTRL_BRANCH] & (bus.alu_zero_i ^ bus.ctrl_i[CTRL_BRANCH_NE]);
  assign w_rd_addr = bus.rd_addr_i;

  always_comb begin
    w_in_entry            = '0;
    w_in_entry.alu_result = bus.alu_result_i;
    w_in_entry.rt_data    = bus.rt_data_i;
    w_in_entry.rd_addr    = w_rd_addr;
    w_in_entry.ctrl       = bus.ctrl_i[CTRL_REG_WRITE:CTRL_MEM_TO_REG];
    w_in_entry.taken      = w_taken;
    w_in_entry.target     = bus.branch_target_i;
  end

  ex_mem_skid_buf u_skid_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_flush (bus.flush_i),
    .i_valid (bus.in_valid_i),
    .o_ready (w_in_ready),
    .i_entry (w_in_entry),
    .o_valid (w_head_valid),
    .i_ready (bus.out_ready_i),
    .o_entry (w_head)
  );

  assign w_redirect = w_head_valid & bus.out_ready_i & w_head.taken & ~bus.flush_i;

  assign bus.in_ready_o    = w_in_ready;
  assign bus.out_valid_o   = w_head_valid;
  assign bus.alu_result_o  = w_head.alu_result;
  assign bus.rt_data_o     = w_head.rt_data;
  assign bus.rd_addr_o     = w_head.rd_addr;
  assign bus.ctrl_o        = w_head.ctrl;
  assign bus.redirect_o    = w_redirect;
  assign bus.redirect_pc_o = w_redirect ? w_head.target : {DATA_W{1'b0}};

`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= 32'd0;
    end else if (w_head_valid && !bus.out_ready_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire
